// File: rtl/mine_board_probe_if.sv
// Reveal request / response channel between the cursor logic and the minefield probe.
// The master issues requests; the slave (the probe) answers with a one-cycle response pulse.
interface mine_board_probe_if #(
  parameter int CW = 4
);
  logic          req_valid;
  logic          req_ready;
  logic [CW-1:0] req_x;
  logic [CW-1:0] req_y;
  logic          rsp_valid;
  logic          rsp_bomb;
  logic [3:0]    rsp_count;
  logic          rsp_already;
  logic          rsp_oob;

  modport master (
    output req_valid, req_x, req_y,
    input  req_ready, rsp_valid, rsp_bomb, rsp_count, rsp_already, rsp_oob
  );

  modport slave (
    input  req_valid, req_x, req_y,
    output req_ready, rsp_valid, rsp_bomb, rsp_count, rsp_already, rsp_oob
  );
endinterface

// File: rtl/mine_board_probe.sv
// Minefield storage plus reveal engine: checks a target cell, scans its 8 neighbours
// one per cycle, stores the adjacent-bomb count and tracks win/lose bookkeeping.
module mine_board_probe #(
  parameter int COLS   = 8,
  parameter int ROWS   = 8,
  parameter int CELL_W = 9,
  parameter int CW     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                ld_en,
  input  logic [CW-1:0]       ld_x,
  input  logic [CW-1:0]       ld_y,
  input  logic                ld_bomb,
  mine_board_probe_if.slave   bus,
  input  logic [CW-1:0]       rd_x,
  input  logic [CW-1:0]       rd_y,
  output logic [CELL_W-1:0]   rd_cell,
  output logic [7:0]          bomb_cnt,
  output logic [7:0]          revealed_cnt,
  output logic                game_over,
  output logic                game_win
);

  localparam int unsigned NCELL = ROWS * COLS;
  localparam int          IW    = $clog2(NCELL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SCAN,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [CELL_W-1:0] cells [NCELL];

  logic [CW-1:0] tx, ty;
  logic [2:0]    nb_idx;
  logic [3:0]    acc;
  logic          r_oob, r_already, r_bomb;

  logic          rsp_valid_q, rsp_bomb_q, rsp_already_q, rsp_oob_q;
  logic [3:0]    rsp_count_q;

  logic          req_ready, accept, load_ok;

  function automatic logic in_bounds(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return ({1'b0, x} < (CW+1)'(COLS)) && ({1'b0, y} < (CW+1)'(ROWS));
  endfunction

  function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
    return IW'({{CW{1'b0}}, y} * (2*CW)'(COLS) + {{CW{1'b0}}, x});
  endfunction

  // Target cell classification, valid while tx/ty hold the latched request
  logic          t_oob, t_rev, t_bomb;
  logic [IW-1:0] t_idx;

  always_comb begin
    t_oob  = !in_bounds(tx, ty);
    t_idx  = cell_idx(tx, ty);
    t_rev  = !t_oob && cells[t_idx][1];
    t_bomb = !t_oob && !t_rev && cells[t_idx][0];
  end

  // Neighbour walk: offset codes 0/1/2 stand for -1/0/+1
  logic [1:0]    dx, dy;
  logic [CW-1:0] nx, ny;
  logic          ok_x, ok_y, nb_bomb;

  always_comb begin
    case (nb_idx)
      3'd0, 3'd3, 3'd5: dx = 2'd0;
      3'd1, 3'd6:       dx = 2'd1;
      default:          dx = 2'd2;
    endcase
    case (nb_idx)
      3'd0, 3'd1, 3'd2: dy = 2'd0;
      3'd3, 3'd4:       dy = 2'd1;
      default:          dy = 2'd2;
    endcase
    nx   = tx;
    ny   = ty;
    ok_x = 1'b1;
    ok_y = 1'b1;
    if (dx == 2'd0) begin
      ok_x = (tx != '0);
      nx   = tx - CW'(1);
    end else if (dx == 2'd2) begin
      ok_x = ({1'b0, tx} + (CW+1)'(1)) < (CW+1)'(COLS);
      nx   = tx + CW'(1);
    end
    if (dy == 2'd0) begin
      ok_y = (ty != '0);
      ny   = ty - CW'(1);
    end else if (dy == 2'd2) begin
      ok_y = ({1'b0, ty} + (CW+1)'(1)) < (CW+1)'(ROWS);
      ny   = ty + CW'(1);
    end
    nb_bomb = ok_x && ok_y && cells[cell_idx(nx, ny)][0];
  end

  logic [IW-1:0] ld_idx;
  logic [8:0]    rev_next9, safe_total9;

  always_comb begin
    ld_idx      = cell_idx(ld_x, ld_y);
    rev_next9   = {1'b0, revealed_cnt} + 9'd1;
    safe_total9 = 9'(NCELL) - {1'b0, bomb_cnt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= S_IDLE;
    else if (clear) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_CHECK;
      S_CHECK: state_nxt = (t_oob || t_rev || t_bomb) ? S_RESP : S_SCAN;
      S_SCAN:  if (nb_idx == 3'd7) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE) && !ld_en && !game_over && !game_win;
    accept    = req_ready && bus.req_valid;
    load_ok   = (state == S_IDLE) && ld_en && (revealed_cnt == '0) && in_bounds(ld_x, ld_y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCELL; i++) cells[i] <= '0;
      tx <= '0; ty <= '0; nb_idx <= '0; acc <= '0;
      r_oob <= 1'b0; r_already <= 1'b0; r_bomb <= 1'b0;
      rsp_valid_q <= 1'b0; rsp_bomb_q <= 1'b0; rsp_already_q <= 1'b0;
      rsp_oob_q <= 1'b0; rsp_count_q <= '0;
      bomb_cnt <= '0; revealed_cnt <= '0; game_over <= 1'b0; game_win <= 1'b0;
    end else if (clear) begin
      for (int unsigned i = 0; i < NCELL; i++) cells[i] <= '0;
      tx <= '0; ty <= '0; nb_idx <= '0; acc <= '0;
      r_oob <= 1'b0; r_already <= 1'b0; r_bomb <= 1'b0;
      rsp_valid_q <= 1'b0; rsp_bomb_q <= 1'b0; rsp_already_q <= 1'b0;
      rsp_oob_q <= 1'b0; rsp_count_q <= '0;
      bomb_cnt <= '0; revealed_cnt <= '0; game_over <= 1'b0; game_win <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_bomb_q    <= 1'b0;
      rsp_already_q <= 1'b0;
      rsp_oob_q     <= 1'b0;
      rsp_count_q   <= '0;
      case (state)
        S_IDLE: begin
          if (load_ok) begin
            cells[ld_idx][0] <= ld_bomb;
            if (ld_bomb && !cells[ld_idx][0])      bomb_cnt <= bomb_cnt + 8'd1;
            else if (!ld_bomb && cells[ld_idx][0]) bomb_cnt <= bomb_cnt - 8'd1;
          end else if (accept) begin
            tx     <= bus.req_x;
            ty     <= bus.req_y;
            nb_idx <= '0;
            acc    <= '0;
          end
        end
        S_CHECK: begin
          r_oob     <= t_oob;
          r_already <= t_rev;
          r_bomb    <= t_bomb;
          if (t_bomb && !game_win) game_over <= 1'b1;
        end
        S_SCAN: begin
          acc    <= acc + {3'b000, nb_bomb};
          nb_idx <= nb_idx + 3'd1;
        end
        S_WRITE: begin
          cells[t_idx][5:1] <= {acc, 1'b1};
          revealed_cnt      <= revealed_cnt + 8'd1;
          if (!game_over && (rev_next9 == safe_total9)) game_win <= 1'b1;
        end
        S_RESP: begin
          rsp_valid_q   <= 1'b1;
          rsp_bomb_q    <= r_bomb;
          rsp_already_q <= r_already;
          rsp_oob_q     <= r_oob;
          rsp_count_q   <= (r_oob || r_already || r_bomb) ? 4'd0 : acc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_cell = in_bounds(rd_x, rd_y) ? cells[cell_idx(rd_x, rd_y)] : '0;
  end

  assign bus.req_ready   = req_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_bomb    = rsp_bomb_q;
  assign bus.rsp_count   = rsp_count_q;
  assign bus.rsp_already = rsp_already_q;
  assign bus.rsp_oob     = rsp_oob_q;

endmodule

// File: doc/mine_board_probe.md
Name: mine_board_probe

Overview:
- Parametrised successor to the combinational single-cell bomb check: owns the minefield storage and answers reveal requests over a valid/ready handshake.
- On a reveal it checks the target cell. A safe cell then has its 8 neighbours scanned sequentially, its adjacent-bomb count stored, and revealed/win/lose bookkeeping updated.
- Sits between the input/cursor logic and the VGA renderer; the renderer reads cell state through a separate read port.

Parameters:
- COLS, 8, board width in cells (2..16)
- ROWS, 8, board height in cells (2..16)
- CELL_W, 9, bits per cell (min 6): bit0 bomb, bit1 revealed, bits[5:2] adjacent count, bits above 5 reserved (written 0)
- CW, 4, coordinate width; must satisfy 2^CW >= max(COLS,ROWS)

Ports:
- clk  in  1  system clock; one clock, all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous board clear; priority over everything
- ld_en  in  1  load strobe
- ld_x  in  CW  load column
- ld_y  in  CW  load row
- ld_bomb  in  1  bomb bit to write
- req_valid  in  1  reveal request
- req_ready  out  1  request accepted when req_valid&&req_ready at a rising edge
- req_x  in  CW  target column X
- req_y  in  CW  target row Y
- rsp_valid  out  1  one-cycle response pulse
- rsp_bomb  out  1  target was a bomb
- rsp_count  out  4  adjacent bombs, 0..8
- rsp_already  out  1  target was already revealed
- rsp_oob  out  1  target outside the board
- rd_x  in  CW  renderer read column
- rd_y  in  CW  renderer read row
- rd_cell  out  CELL_W  combinational cell(rd_x,rd_y); 0 if out of bounds
- bomb_cnt  out  8  bombs on board
- revealed_cnt  out  8  safe cells revealed
- game_over  out  1  sticky lose flag
- game_win  out  1  sticky win flag

Behaviour:
- Reset (async) and clear (sync): all cells 0, counters 0, flags 0, rsp_* 0, state IDLE. Clear mid-operation aborts the operation with no rsp_valid.
- Cell indexing: cell(X,Y) is row Y, column X. In bounds iff X<COLS and Y<ROWS.
- req_ready = (state==IDLE) && !ld_en && !game_over && !game_win.
- Load:
  - Honoured only in IDLE with revealed_cnt==0 and coordinates in bounds; otherwise ignored.
  - Writes bit0 only.
  - bomb_cnt +1 on a 0->1 transition, -1 on 1->0, unchanged on a rewrite of the same value.
  - Takes precedence over req_valid in the same cycle.
- FSM: IDLE -> CHECK -> {RESP | SCAN} -> WRITE -> RESP -> IDLE.
  - IDLE: accepting edge latches X,Y.
  - CHECK, one cycle, first match wins:
    - out of bounds: rsp_oob=1, go to RESP
    - revealed: rsp_already=1, go to RESP
    - bomb: rsp_bomb=1, set game_over, go to RESP
    - otherwise: go to SCAN
  - SCAN, exactly 8 cycles, one neighbour per cycle in the order (-1,-1),(0,-1),(+1,-1),(-1,0),(+1,0),(-1,+1),(0,+1),(+1,+1).
    - Off-board neighbours contribute 0; no wrap-around at edges.
    - The 4-bit accumulator adds the neighbour's bit0.
  - WRITE:
    - Sets cell bit1=1 and bits[5:2]=count; revealed_cnt +1.
    - If revealed_cnt+1 == ROWS*COLS - bomb_cnt, set game_win.
  - RESP: rsp_valid=1 for one cycle with rsp_bomb/rsp_count/rsp_already/rsp_oob stable. All rsp_* return to 0 on the next edge.
- Latency: rsp_valid is high in the cycle after edge N, counting the accepting edge as 0.
  - N=2 for oob, already-revealed and bomb.
  - N=11 for a safe reveal (CHECK, 8×SCAN, WRITE, RESP).
- rsp_count=0 unless the reveal is safe.
- game_over and game_win are sticky; only rst or clear deasserts them. Neither can set once the other is set.
- Empty board (bomb_cnt==0): wins after all ROWS*COLS cells are revealed.

Test Plan:
- Reset, no load; rd_x=0, rd_y=0 -> rd_cell=0, bomb_cnt=0, req_ready=1, all rsp_* 0.
- Load bombs at (1,0),(0,1),(1,1); reveal (0,0) -> rsp_valid 11 edges after accept, rsp_count=3; rd_cell(0,0) bits[5:2]=3, bit1=1; revealed_cnt=1.
- Same board, reveal (0,0) again -> rsp_already=1, rsp_count=0, latency 2, revealed_cnt stays 1. Reveal (9,2) -> rsp_oob=1.
- Reveal (1,1) -> rsp_bomb=1 at latency 2, game_over=1, req_ready=0; further req_valid is ignored.
- 2×2 board (ROWS=COLS=2), single bomb at (1,1); reveal the other three cells -> each rsp_count=1; game_win=1 after the third WRITE.
- Assert clear in SCAN cycle 4 -> no rsp_valid, all cells 0, state IDLE. Assert rst mid-SCAN -> outputs 0 immediately. Loading the same bomb twice leaves bomb_cnt=1.
